// File: rtl/fetch_stage.sv
// WISC instruction-fetch stage: owns the PC, talks to a variable-latency
// instruction memory and feeds decode through an IF/ID slot backed by a one-entry skid buffer.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_next,
    output logic        halted,
    output logic        err
);
    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] HALTED = 2'd3;

    logic [1:0]  state;
    logic [15:0] pc, target, buf_instr, buf_pc;
    logic        pending_halt;
    logic [15:0] pc_inc, redir_aligned;
    logic        consume;

    assign pc_inc        = pc + 16'd2;
    assign redir_aligned = {redirect_pc[15:1], 1'b0};
    assign consume       = if_valid && !stall;
    assign imem_req      = rst_n && (state == FETCH || state == DRAIN);
    // In DRAIN pc still holds the outstanding address; the new target waits in target
    assign imem_addr     = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            target       <= RESET_PC;
            buf_instr    <= NOP_INSTR;
            buf_pc       <= 16'h0000;
            pending_halt <= 1'b0;
            if_valid     <= 1'b0;
            if_instr     <= NOP_INSTR;
            if_pc        <= 16'h0000;
            if_pc_next   <= 16'h0000;
            halted       <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (consume) begin
                if_valid <= 1'b0;
                if_instr <= NOP_INSTR;
            end
            case (state)
                FETCH: begin
                    if (redirect) begin
                        err          <= err | redirect_pc[0];
                        pending_halt <= 1'b0;
                        if_valid     <= 1'b0;
                        if_instr     <= NOP_INSTR;
                        if (imem_done) pc <= redir_aligned;
                        else begin
                            target <= redir_aligned;
                            state  <= DRAIN;
                        end
                    end else if (halt) begin
                        if (!imem_done) begin
                            pending_halt <= 1'b1;
                            target       <= pc;
                            state        <= DRAIN;
                        end else begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end
                    end else if (imem_done) begin
                        pc <= pc_inc;
                        if (!if_valid || !stall) begin
                            if_valid   <= 1'b1;
                            if_instr   <= imem_rdata;
                            if_pc      <= pc;
                            if_pc_next <= pc_inc;
                        end else begin
                            buf_instr <= imem_rdata;
                            buf_pc    <= pc;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        err          <= err | redirect_pc[0];
                        pending_halt <= 1'b0;
                        if_valid     <= 1'b0;
                        if_instr     <= NOP_INSTR;
                        pc           <= redir_aligned;
                        state        <= FETCH;
                    end else if (halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (!stall) begin
                        if_valid   <= 1'b1;
                        if_instr   <= buf_instr;
                        if_pc      <= buf_pc;
                        if_pc_next <= buf_pc + 16'd2;
                        state      <= FETCH;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        err          <= err | redirect_pc[0];
                        pending_halt <= 1'b0;
                        if_valid     <= 1'b0;
                        if_instr     <= NOP_INSTR;
                        if (imem_done) begin
                            pc    <= redir_aligned;
                            state <= FETCH;
                        end else target <= redir_aligned;
                    end else begin
                        // A halt seen while draining waits for the outstanding request
                        // so the memory never sees a request withdrawn mid-flight.
                        if (halt) pending_halt <= 1'b1;
                        if (imem_done) begin
                            if (pending_halt || halt) begin
                                state  <= HALTED;
                                halted <= 1'b1;
                            end else begin
                                pc    <= target;
                                state <= FETCH;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Pipelined instruction-fetch stage for the WISC processor. It owns the PC, issues requests to a variable-latency instruction memory, and presents fetched instructions to decode through an IF/ID output slot with a one-entry skid buffer. It also handles branch/jump redirects from execute and the halt signal from decode. Decode consumes the slot directly.

## Interface

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_INSTR, 16'h0800, value driven on if_instr when the slot is empty

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  decode cannot accept the slot this cycle
- redirect  in  1  execute resolved a taken branch/jump this cycle
- redirect_pc  in  16  target PC, valid when redirect=1
- halt  in  1  decode holds a HALT instruction this cycle
- imem_req  out  1  instruction-memory request
- imem_addr  out  16  request address, stable while imem_req=1 and imem_done=0
- imem_rdata  in  16  instruction word, valid when imem_done=1
- imem_done  in  1  memory completes the current request this cycle
- if_valid  out  1  slot holds a valid instruction
- if_instr  out  16  slot instruction
- if_pc  out  16  address of if_instr
- if_pc_next  out  16  if_pc + 2
- halted  out  1  fetch has stopped permanently
- err  out  1  sticky; set when a redirect to an odd address is accepted

## Operation

State machine: FETCH, HOLD, DRAIN, HALTED. Internal registers: pc, target, buffer (instr/pc), pending_halt.

- **FETCH:** imem_req=1, imem_addr=pc.
  - If redirect=1: if imem_done=1, pc<=redirect_pc and state stays FETCH. Otherwise target<=redirect_pc and state goes to DRAIN. In both cases the returned data is discarded.
  - Else if imem_done=1 and the slot is free or being consumed (!if_valid || !stall): slot<=(imem_rdata, pc, pc+2), pc<=pc+2.
  - Else if imem_done=1 and the slot is full with stall=1: buffer<=(imem_rdata, pc), pc<=pc+2, state goes to HOLD.
- **HOLD:** imem_req=0.
  - redirect=1: drop the buffer, pc<=redirect_pc, go to FETCH.
  - Else if stall=0: slot<=buffer, go to FETCH.
- **DRAIN:** imem_req=1, imem_addr=old pc.
  - A further redirect overwrites target; the latest redirect wins.
  - On imem_done: discard the data, pc<=target, go to FETCH, or go to HALTED if pending_halt=1.
- **Halt:** on halt=1 with redirect=0:
  - From FETCH with no imem_done: set pending_halt and go to DRAIN with target=pc.
  - From any other case: go to HALTED.
- **HALTED:** imem_req=0, halted=1. Only reset exits this state.
- **Redirect priority:** redirect has priority over halt in the same cycle, because the halt is on the wrong path. pending_halt is cleared by any redirect.
- **Slot rules:**
  - A redirect clears if_valid regardless of stall.
  - A valid slot with stall=0 is consumed at the edge; if nothing new is loaded, if_valid<=0.
  - When if_valid=0, if_instr=NOP_INSTR.
- **Redirect alignment:** redirect_pc[0]=1 sets err. The PC loads {redirect_pc[15:1],1'b0}.
- **Arithmetic:** pc+2 is 16-bit and wraps from 16'hFFFE to 16'h0000 without error.

## Timing

- **Reset values:** pc=RESET_PC, state=FETCH, if_valid=0, if_instr=NOP_INSTR, if_pc=0, if_pc_next=0, halted=0, err=0. imem_req is forced to 0 while rst_n=0.
- **Reset mid-request:** reset abandons any outstanding request. The memory model must accept a fresh request after reset deasserts.
- **Latency:** imem_done in cycle N gives if_valid=1 in cycle N+1.
- **Throughput:** one instruction per cycle when imem_done=1 every cycle and stall=0. Requests issue back to back, and imem_addr changes on the edge after imem_done.
- **Stall:** no request issues in HOLD. At most one fetched instruction is ever held beyond the slot.
- **Redirect:** redirect in cycle N gives imem_addr=redirect_pc in cycle N+1 when no request is outstanding or imem_done=1 in N. Otherwise it follows the cycle after the drained imem_done.
- **Outputs:** if_* and halted are registered. imem_req and imem_addr are decoded from state and pc.

## Test plan

- **Sequential fetch:** reset with RESET_PC=0 and imem_done tied to 1, returning instr=addr^16'hA5A5 -> if_pc = 0,2,4,6 on consecutive cycles from cycle 1, with if_pc_next=if_pc+2.
- **Stall with skid:** stall=1 for 3 cycles while if_pc=4 -> slot holds pc 4, the buffer holds pc 6, and imem_req=0 from the 2nd stalled cycle. After stall drops, pcs 6 and 8 arrive with no loss or duplication.
- **Redirect during outstanding request:** imem_done held at 0 for 3 cycles after request at 16'h0010, redirect to 16'h0100 in the first cycle -> imem_addr stays 16'h0010 until done, that data is discarded, then imem_addr=16'h0100 and the next if_pc=16'h0100.
- **Redirect and halt together:** redirect to 16'h0040, halt=1 and imem_done=1 in the same cycle -> halted stays 0, the data is dropped, and the next if_pc=16'h0040.
- **Halt:** halt=1 with a request outstanding -> imem_req stays 1 until imem_done, then halted=1 and imem_req=0 forever. Odd redirect 16'h0021 -> err=1 and imem_addr=16'h0020.
- **Reset mid-request and wrap-around:** rst_n pulsed low mid-request -> all outputs return to reset values immediately. PC at 16'hFFFE -> next fetch address 16'h0000.
